// File: rtl/gpsreceiver2_pkg.sv
// gpsreceiver2 capture path: shared encodings and defaults.
// Status flag indices match the CSR status register layout.
package gpsreceiver2_pkg;

    localparam int GPS_ADR_W   = 11;
    localparam int GPS_SYNC_TO = 4095;

    localparam int ST_OVF_BIT     = 0;
    localparam int ST_TIMEOUT_BIT = 1;
    localparam int ST_SYNCERR_BIT = 2;
    localparam int ST_W           = 3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_SYNC = 3'd1,
        S_CAPTURE   = 3'd2,
        S_SWAP      = 3'd3,
        S_STALL     = 3'd4
    } cap_state_e;

endpackage

// File: rtl/gpsreceiver2_sync2.sv
// Two-flop synchroniser with a third flop for edge detection.
// All flops clear on reset so release never produces an edge.
module gpsreceiver2_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] tgl
);

    logic [W-1:0] meta;
    logic [W-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
            prev <= '0;
        end else begin
            meta <= d;
            q    <= meta;
            prev <= q;
        end
    end

    assign tgl = q ^ prev;

endmodule

// File: rtl/gpsreceiver2_capture_ctl.sv
// gpsreceiver2 capture sequencer: arm/sync wait, ping-pong bank
// write addressing, bank full bookkeeping and sticky status.
module gpsreceiver2_capture_ctl
    import gpsreceiver2_pkg::*;
#(
    parameter int ADR_W   = GPS_ADR_W,
    parameter int SYNC_TO = GPS_SYNC_TO
) (
    input  logic             gps_rec_clk,
    input  logic             gps_rec_rst_n,
    input  logic             csr_arm,
    input  logic             csr_cont,
    input  logic [ADR_W:0]   csr_len,
    input  logic [1:0]       csr_ack,
    input  logic             rx_sync,
    input  logic             rx_byte_vld,
    output logic             rx_en,
    output logic             wr_we,
    output logic             wr_bank,
    output logic [ADR_W-1:0] wr_adr,
    output logic [1:0]       bank_full,
    output logic [ADR_W:0]   bank_len0,
    output logic [ADR_W:0]   bank_len1,
    output logic             st_ovf,
    output logic             st_timeout,
    output logic             st_syncerr,
    output logic [15:0]      drop_cnt,
    output logic             busy
);

    localparam int LW = ADR_W + 1;
    localparam int TW = $clog2(SYNC_TO + 1);
    localparam logic [LW-1:0] DEPTH = {1'b1, {ADR_W{1'b0}}};

    logic       arm_q, arm_tgl, cont_q;
    logic [1:0] ack_tgl;
    logic       unused_cont_tgl;
    logic [1:0] unused_ack_q;

    gpsreceiver2_sync2 #(.W(1)) u_arm (
        .clk(gps_rec_clk), .rst_n(gps_rec_rst_n),
        .d(csr_arm), .q(arm_q), .tgl(arm_tgl)
    );
    gpsreceiver2_sync2 #(.W(1)) u_cont (
        .clk(gps_rec_clk), .rst_n(gps_rec_rst_n),
        .d(csr_cont), .q(cont_q), .tgl(unused_cont_tgl)
    );
    gpsreceiver2_sync2 #(.W(2)) u_ack (
        .clk(gps_rec_clk), .rst_n(gps_rec_rst_n),
        .d(csr_ack), .q(unused_ack_q), .tgl(ack_tgl)
    );

    logic arm_rise, arm_fall;
    assign arm_rise = arm_tgl & arm_q;
    assign arm_fall = arm_tgl & ~arm_q;

    cap_state_e    state_q, state_d;
    logic [LW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          sync_lo_q, sync_lo_d;
    logic          bank_q, bank_d;
    logic [1:0]    full_q, full_d, set_full;
    logic [LW-1:0] len0_q, len0_d, len1_q, len1_d, set_len;
    logic [ST_W-1:0] st_q, st_d;
    logic [15:0]   drop_q, drop_d;
    logic          drop_inc;
    logic [LW-1:0] eff_len;

    // Out-of-range lengths fall back to a full bank.
    assign eff_len = (csr_len == '0 || csr_len > DEPTH) ? DEPTH : csr_len;

    always_ff @(posedge gps_rec_clk or negedge gps_rec_rst_n) begin
        if (!gps_rec_rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            timer_q   <= '0;
            sync_lo_q <= 1'b0;
            bank_q    <= 1'b0;
            full_q    <= '0;
            len0_q    <= '0;
            len1_q    <= '0;
            st_q      <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            sync_lo_q <= sync_lo_d;
            bank_q    <= bank_d;
            full_q    <= full_d;
            len0_q    <= len0_d;
            len1_q    <= len1_d;
            st_q      <= st_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        timer_d   = timer_q;
        sync_lo_d = sync_lo_q;
        bank_d    = bank_q;
        st_d      = st_q;
        drop_d    = drop_q;
        set_full  = '0;
        set_len   = count_q;
        drop_inc  = 1'b0;
        rx_en     = 1'b0;
        wr_we     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (arm_rise && full_q != 2'b11) begin
                    state_d = S_WAIT_SYNC;
                    st_d    = '0;
                    drop_d  = '0;
                    count_d = '0;
                    timer_d = '0;
                    bank_d  = full_q[0];
                end
            end
            S_WAIT_SYNC: begin
                sync_lo_d = 1'b0;
                if (rx_sync) begin
                    state_d = S_CAPTURE;
                end else if (timer_q == TW'(SYNC_TO)) begin
                    st_d[ST_TIMEOUT_BIT] = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_CAPTURE: begin
                rx_en     = 1'b1;
                wr_we     = rx_byte_vld;
                sync_lo_d = ~rx_sync;
                if (rx_byte_vld) count_d = count_q + LW'(1);
                if (!rx_sync && sync_lo_q) begin
                    st_d[ST_SYNCERR_BIT] = 1'b1;
                    state_d = S_IDLE;
                    if (count_d != '0) begin
                        set_full[bank_q] = 1'b1;
                        set_len = count_d;
                    end
                end else if (rx_byte_vld && count_q == eff_len - LW'(1)) begin
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                drop_inc         = rx_byte_vld;
                set_full[bank_q] = 1'b1;
                set_len          = eff_len;
                sync_lo_d        = 1'b0;
                if (!cont_q) begin
                    state_d = S_IDLE;
                end else if (!full_q[~bank_q]) begin
                    bank_d  = ~bank_q;
                    count_d = '0;
                    state_d = S_CAPTURE;
                end else begin
                    st_d[ST_OVF_BIT] = 1'b1;
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                rx_en     = 1'b1;
                drop_inc  = rx_byte_vld;
                sync_lo_d = 1'b0;
                if (!full_q[~bank_q]) begin
                    bank_d  = ~bank_q;
                    count_d = '0;
                    state_d = S_CAPTURE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort drops the partial bank; status flags survive.
        if (arm_fall) begin
            state_d  = S_IDLE;
            set_full = '0;
        end
        if (drop_inc && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        full_d = (full_q & ~ack_tgl) | set_full;
        len0_d = set_full[0] ? set_len : len0_q;
        len1_d = set_full[1] ? set_len : len1_q;
    end

    assign wr_bank    = bank_q;
    assign wr_adr     = count_q[ADR_W-1:0];
    assign bank_full  = full_q;
    assign bank_len0  = len0_q;
    assign bank_len1  = len1_q;
    assign st_ovf     = st_q[ST_OVF_BIT];
    assign st_timeout = st_q[ST_TIMEOUT_BIT];
    assign st_syncerr = st_q[ST_SYNCERR_BIT];
    assign drop_cnt   = drop_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_gpsreceiver2_capture_ctl.sv
// Directed bench for gpsreceiver2_capture_ctl with a write scoreboard.
// Small geometry: 16-byte banks, 16-cycle sync timeout.
module tb_gpsreceiver2_capture_ctl;

    localparam int ADR_W   = 4;
    localparam int SYNC_TO = 16;

    logic             clk;
    logic             rst_n;
    logic             csr_arm;
    logic             csr_cont;
    logic [ADR_W:0]   csr_len;
    logic [1:0]       csr_ack;
    logic             rx_sync;
    logic             rx_byte_vld;
    logic             rx_en;
    logic             wr_we;
    logic             wr_bank;
    logic [ADR_W-1:0] wr_adr;
    logic [1:0]       bank_full;
    logic [ADR_W:0]   bank_len0;
    logic [ADR_W:0]   bank_len1;
    logic             st_ovf;
    logic             st_timeout;
    logic             st_syncerr;
    logic [15:0]      drop_cnt;
    logic             busy;

    int checks = 0;
    int errors = 0;
    logic [ADR_W:0] sb[$];

    gpsreceiver2_capture_ctl #(.ADR_W(ADR_W), .SYNC_TO(SYNC_TO)) dut (
        .gps_rec_clk(clk),
        .gps_rec_rst_n(rst_n),
        .csr_arm(csr_arm),
        .csr_cont(csr_cont),
        .csr_len(csr_len),
        .csr_ack(csr_ack),
        .rx_sync(rx_sync),
        .rx_byte_vld(rx_byte_vld),
        .rx_en(rx_en),
        .wr_we(wr_we),
        .wr_bank(wr_bank),
        .wr_adr(wr_adr),
        .bank_full(bank_full),
        .bank_len0(bank_len0),
        .bank_len1(bank_len1),
        .st_ovf(st_ovf),
        .st_timeout(st_timeout),
        .st_syncerr(st_syncerr),
        .drop_cnt(drop_cnt),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input bit wr, input logic bk,
                          input logic [ADR_W-1:0] adr, input int gap);
        if (wr) sb.push_back({bk, adr});
        rx_byte_vld = 1'b1;
        tick();
        rx_byte_vld = 1'b0;
        tick(gap);
    endtask

    task automatic wait_rx_en();
        for (int i = 0; i < 20 && !rx_en; i++) tick();
        chk("rx_en_up", 64'(rx_en), 64'd1);
    endtask

    function automatic logic [63:0] all_out();
        return 64'({rx_en, wr_we, wr_bank, wr_adr, bank_full, bank_len0,
                    bank_len1, st_ovf, st_timeout, st_syncerr, drop_cnt,
                    busy});
    endfunction

    always @(negedge clk) begin
        if (rst_n && wr_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_wr", 64'({wr_bank, wr_adr}), 64'hFFFF);
            end else begin
                chk("wr_addr", 64'({wr_bank, wr_adr}), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        rst_n = 1'b0; csr_arm = 1'b0; csr_cont = 1'b0; csr_len = '0;
        csr_ack = 2'b00; rx_sync = 1'b0; rx_byte_vld = 1'b0;
        tick(3);
        chk("reset_outs", all_out(), 64'd0);
        rst_n = 1'b1;
        tick(3);
        chk("idle_after_rst", all_out(), 64'd0);

        // T1 single shot, 8 bytes
        csr_len = 5'd8; rx_sync = 1'b1; csr_arm = 1'b1;
        wait_rx_en();
        for (int i = 0; i < 8; i++) strobe(1, 1'b0, 4'(i), 1);
        tick(2);
        chk("t1_full", 64'(bank_full), 64'b01);
        chk("t1_len0", 64'(bank_len0), 64'd8);
        chk("t1_busy", 64'(busy), 64'd0);
        csr_arm = 1'b0;
        tick(4);
        csr_ack[0] = ~csr_ack[0];
        tick(2);
        chk("ack_lat2", 64'(bank_full), 64'b01);
        tick();
        chk("ack_lat3", 64'(bank_full), 64'b00);

        // T2 continuous, len 4, no acks -> overflow
        csr_len = 5'd4; csr_cont = 1'b1; csr_arm = 1'b1;
        wait_rx_en();
        for (int i = 0; i < 4; i++) strobe(1, 1'b0, 4'(i), 2);
        for (int i = 0; i < 4; i++) strobe(1, 1'b1, 4'(i), 2);
        for (int i = 0; i < 4; i++) strobe(0, 1'b0, 4'd0, 2);
        chk("t2_full", 64'(bank_full), 64'b11);
        chk("t2_len0", 64'(bank_len0), 64'd4);
        chk("t2_len1", 64'(bank_len1), 64'd4);
        chk("t2_ovf", 64'(st_ovf), 64'd1);
        chk("t2_drop", 64'(drop_cnt), 64'd4);
        chk("t2_stall", 64'({busy, rx_en}), 64'b11);

        // T3 free bank 0 and resume there
        csr_ack[0] = ~csr_ack[0];
        tick(2);
        chk("t3_full_pre", 64'(bank_full), 64'b11);
        tick();
        chk("t3_full_post", 64'(bank_full), 64'b10);
        tick();
        strobe(1, 1'b0, 4'd0, 1);
        chk("t3_bank", 64'(wr_bank), 64'd0);
        csr_arm = 1'b0;
        tick(4);
        chk("abort_idle", 64'(busy), 64'd0);
        chk("abort_full", 64'(bank_full), 64'b10);
        chk("abort_flags", 64'({st_ovf, drop_cnt}), 64'h1_0004);
        csr_ack[1] = ~csr_ack[1];
        tick(4);
        chk("ack1_free", 64'(bank_full), 64'b00);

        // T4 sync timeout
        rx_sync = 1'b0; csr_cont = 1'b0; csr_arm = 1'b1;
        for (int i = 0; i < 20 && !busy; i++) tick();
        n = 0;
        seen = 1'b0;
        while (busy && n < 40) begin
            tick();
            n++;
            if (rx_en) seen = 1'b1;
        end
        chk("t4_wait_cycles", 64'(n), 64'(SYNC_TO + 1));
        chk("t4_timeout", 64'(st_timeout), 64'd1);
        chk("t4_rx_en", 64'(seen), 64'd0);
        chk("t4_cleared", 64'({st_ovf, drop_cnt}), 64'd0);
        csr_arm = 1'b0;
        tick(4);

        // T5 sync lost after 5 bytes
        csr_len = 5'd8; rx_sync = 1'b1; csr_arm = 1'b1;
        wait_rx_en();
        for (int i = 0; i < 5; i++) strobe(1, 1'b0, 4'(i), 1);
        rx_sync = 1'b0;
        tick();
        chk("t5_one_low", 64'(busy), 64'd1);
        tick();
        chk("t5_idle", 64'(busy), 64'd0);
        chk("t5_syncerr", 64'({st_syncerr, st_timeout}), 64'b10);
        chk("t5_full", 64'(bank_full), 64'b01);
        chk("t5_len0", 64'(bank_len0), 64'd5);
        csr_arm = 1'b0;
        csr_ack[0] = ~csr_ack[0];
        tick(5);

        // T6 async reset mid-capture, then len=0 run
        rx_sync = 1'b1; csr_len = 5'd0; csr_arm = 1'b1;
        wait_rx_en();
        for (int i = 0; i < 3; i++) strobe(1, 1'b0, 4'(i), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_rst", all_out(), 64'd0);
        csr_arm = 1'b0;
        csr_ack = 2'b00;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        csr_arm = 1'b1;
        wait_rx_en();
        for (int i = 0; i < 16; i++) strobe(1, 1'b0, 4'(i), 1);
        tick(2);
        chk("t6_full", 64'(bank_full), 64'b01);
        chk("t6_len_depth", 64'(bank_len0), 64'd16);
        chk("t6_idle", 64'(busy), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
